// File: rtl/inert_sensor_resp.sv
// SPI responder standing in for the inertial sensor: small config register file,
// pitch-rate / Z-accel readback from a per-sample snapshot, and the data-ready INT.
module inert_sensor_resp #(
   parameter logic [15:0] SMPL_PERIOD = 16'd4096,
   parameter logic [7:0]  WHO_AM_I    = 8'h6A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_rt_in,
   input  logic [15:0] az_in,
   output logic        setup_done
);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t r_state, w_nxt_state;

   logic [2:0]  r_ss_sync, r_sclk_sync;
   logic [1:0]  r_mosi_sync;
   logic [1:0]  r_warm;
   logic        r_armed;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_rx;
   logic [7:0]  r_tx;
   logic [7:0]  r_int1_ctrl, r_ctrl1_xl, r_ctrl2_g, r_ctrl5;
   logic [15:0] r_snap_ptch, r_snap_az, r_smpl_cnt;
   logic        r_int, r_pending, r_setup_done;
   logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
   logic        w_frame_start, w_frame_end, w_full_frame, w_wr, w_int_clr;
   logic        w_tick, w_take;
   logic [7:0]  w_rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_sync   <= '1;
         r_sclk_sync <= '1;
         r_mosi_sync <= '0;
      end else begin
         r_ss_sync   <= {r_ss_sync[1:0], SS_n};
         r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
         r_mosi_sync <= {r_mosi_sync[0], MOSI};
      end
   end

   assign w_ss_fall   =  r_ss_sync[2]   & ~r_ss_sync[1];
   assign w_ss_rise   = ~r_ss_sync[2]   &  r_ss_sync[1];
   assign w_sclk_rise = ~r_sclk_sync[2] &  r_sclk_sync[1];
   assign w_sclk_fall =  r_sclk_sync[2] & ~r_sclk_sync[1];

   // The SS_n sync chain resets high, so a reset taken mid-frame would fake a fall;
   // frames are only accepted once SS_n has been seen genuinely high after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_warm  <= '0;
         r_armed <= 1'b0;
      end else begin
         if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
         if (r_warm == 2'd3 && r_ss_sync[1]) r_armed <= 1'b1;
      end
   end

   assign w_frame_start = (r_state == IDLE) && w_ss_fall && r_armed;
   assign w_frame_end   = (r_state == SHIFT) && w_ss_rise;
   assign w_full_frame  = w_frame_end && (r_bit_cnt == 5'd16);
   assign w_wr          = w_full_frame && !r_rx[15];
   assign w_int_clr     = w_full_frame && r_rx[15] && (r_rx[14:8] == 7'h22);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nxt_state;
   end

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         IDLE:  if (w_frame_start) w_nxt_state = SHIFT;
         SHIFT: if (w_ss_rise)     w_nxt_state = IDLE;
      endcase
   end

   always_comb begin
      w_rd_data = '0;
      case (r_rx[6:0])
         7'h0D: w_rd_data = r_int1_ctrl;
         7'h0F: w_rd_data = WHO_AM_I;
         7'h10: w_rd_data = r_ctrl1_xl;
         7'h11: w_rd_data = r_ctrl2_g;
         7'h14: w_rd_data = r_ctrl5;
         7'h22: w_rd_data = r_snap_ptch[7:0];
         7'h23: w_rd_data = r_snap_ptch[15:8];
         7'h2C: w_rd_data = r_snap_az[7:0];
         7'h2D: w_rd_data = r_snap_az[15:8];
         default: w_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_rx      <= '0;
         r_tx      <= '0;
      end else if (w_frame_start) begin
         r_bit_cnt <= '0;
         r_rx      <= '0;
         r_tx      <= '0;
      end else if (r_state == SHIFT) begin
         if (w_sclk_rise) begin
            r_rx <= {r_rx[14:0], r_mosi_sync[1]};
            if (r_bit_cnt != 5'd16) r_bit_cnt <= r_bit_cnt + 5'd1;
         end
         if (w_sclk_fall) begin
            if (r_bit_cnt == 5'd8)
               r_tx <= w_rd_data;
            else if (r_bit_cnt > 5'd8 && r_bit_cnt < 5'd16)
               r_tx <= {r_tx[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_int1_ctrl <= '0;
         r_ctrl1_xl  <= '0;
         r_ctrl2_g   <= '0;
         r_ctrl5     <= '0;
      end else if (w_wr) begin
         case (r_rx[14:8])
            7'h0D: r_int1_ctrl <= r_rx[7:0];
            7'h10: r_ctrl1_xl  <= r_rx[7:0];
            7'h11: r_ctrl2_g   <= r_rx[7:0];
            7'h14: r_ctrl5     <= r_rx[7:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_setup_done <= 1'b0;
      else r_setup_done <= (r_int1_ctrl == 8'h02) && (r_ctrl2_g != 8'h00) && (r_ctrl1_xl != 8'h00);
   end

   assign w_tick = r_setup_done && (r_smpl_cnt == SMPL_PERIOD - 16'd1);
   // Samples are taken only outside a frame (the frame-end cycle counts as outside),
   // so a frame's bytes come from one snapshot and a new sample beats the INT clear.
   assign w_take = (w_tick || r_pending) && ((r_state == IDLE) || w_frame_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_smpl_cnt  <= '0;
         r_pending   <= 1'b0;
         r_snap_ptch <= '0;
         r_snap_az   <= '0;
         r_int       <= 1'b0;
      end else begin
         if (!r_setup_done || w_tick) r_smpl_cnt <= '0;
         else                         r_smpl_cnt <= r_smpl_cnt + 16'd1;
         if (w_take)      r_pending <= 1'b0;
         else if (w_tick) r_pending <= 1'b1;
         if (w_take) begin
            r_snap_ptch <= ptch_rt_in;
            r_snap_az   <= az_in;
         end
         if (w_take)         r_int <= 1'b1;
         else if (w_int_clr) r_int <= 1'b0;
      end
   end

   assign MISO       = (r_state == SHIFT) & r_tx[7];
   assign INT        = r_int;
   assign setup_done = r_setup_done;

endmodule

// File: tb/tb_inert_sensor_resp.sv
// Directed SPI stimulus for inert_sensor_resp; expected read frames go into a
// scoreboard queue and a frame monitor compares what comes back on MISO.
module tb_inert_sensor_resp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic        INT;
   logic [15:0] ptch_rt_in = 16'hFE37;
   logic [15:0] az_in = 16'h0123;
   logic        setup_done;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        chk;
      logic [15:0] exp;
      logic [7:0]  cmd;
   } sb_t;
   sb_t sb[$];

   int          mon_cnt = 0;
   logic [15:0] mon_sr = '0;

   inert_sensor_resp #(.SMPL_PERIOD(16'd64), .WHO_AM_I(8'h6A)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .INT(INT), .ptch_rt_in(ptch_rt_in), .az_in(az_in), .setup_done(setup_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial forever begin
      @(negedge SS_n);
      mon_cnt = 0;
      mon_sr  = '0;
   end

   initial forever begin
      @(posedge SCLK);
      if (SS_n == 1'b0) begin
         mon_sr = {mon_sr[14:0], MISO};
         mon_cnt++;
      end
   end

   initial forever begin
      sb_t e;
      @(posedge SS_n);
      if (mon_cnt == 16) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got frame %h, expected none", mon_sr);
         end else begin
            e = sb.pop_front();
            if (e.chk) check($sformatf("read_%02h", e.cmd), mon_sr, e.exp);
         end
      end
      mon_cnt = 0;
   end

   task automatic spi_frame(input logic [15:0] cmd, input int nbits, input logic chk,
                            input logic [7:0] exp_byte);
      sb_t e;
      if (nbits == 16) begin
         e.chk = chk;
         e.exp = {8'h00, exp_byte};
         e.cmd = cmd[15:8];
         sb.push_back(e);
      end
      SS_n = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = cmd[15-i];
         #80;
         SCLK = 1'b1;
         #80;
      end
      #100;
      SS_n = 1'b1;
   endtask

   task automatic rd(input logic [15:0] cmd, input logic [7:0] exp_byte);
      spi_frame(cmd, 16, 1'b1, exp_byte);
      #200;
   endtask

   task automatic wr(input logic [15:0] cmd);
      spi_frame(cmd, 16, 1'b0, 8'h00);
      #200;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      int   dips;

      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      #100;

      // reset state and WHO_AM_I
      @(negedge clk);
      check("int_reset", {15'd0, INT}, 16'd0);
      check("setup_done_reset", {15'd0, setup_done}, 16'd0);
      rd(16'h8F00, 8'h6A);
      rd(16'h8100, 8'h00);
      wr(16'h0F11);
      rd(16'h8F00, 8'h6A);

      // aborted write leaves INT1_CTRL alone; next frames decode normally
      spi_frame(16'h0D02, 10, 1'b0, 8'h00);
      #200;
      rd(16'h8D00, 8'h00);
      wr(16'h1455);
      rd(16'h9400, 8'h55);
      @(negedge clk);
      check("setup_done_after_abort", {15'd0, setup_done}, 16'd0);

      // configuration
      wr(16'h0D02);
      wr(16'h1053);
      check("setup_done_partial", {15'd0, setup_done}, 16'd0);
      spi_frame(16'h1150, 16, 1'b0, 8'h00);
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(negedge clk);
         if (setup_done) found = 1'b1;
      end
      check("setup_done_rise", {15'd0, found}, 16'd1);
      check("int_low_at_setup", {15'd0, INT}, 16'd0);
      found = 1'b0;
      for (int k = 0; k < 66 && !found; k++) begin
         @(negedge clk);
         if (INT) found = 1'b1;
      end
      check("int_latency_le66", {15'd0, found}, 16'd1);
      wr(16'h1460);
      rd(16'h9100, 8'h50);

      // snapshot readback, then INT clear once sampling is stopped
      rd(16'hA300, 8'hFE);
      rd(16'hAC00, 8'h23);
      rd(16'hAD00, 8'h01);
      wr(16'h0D00);
      check("setup_done_off", {15'd0, setup_done}, 16'd0);
      check("int_before_clear", {15'd0, INT}, 16'd1);
      rd(16'hA200, 8'h37);
      check("int_after_clear", {15'd0, INT}, 16'd0);

      // tick during a frame: bytes from the old sample, new one after frame end
      wr(16'h0D02);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (INT) found = 1'b1;
      end
      check("int_rise_reenable", {15'd0, found}, 16'd1);
      ptch_rt_in = 16'hABCD;
      az_in      = 16'h4567;
      rd(16'hA300, 8'hFE);
      rd(16'hA300, 8'hAB);
      rd(16'hAD00, 8'h45);
      spi_frame(16'hA200, 16, 1'b1, 8'hCD);
      dips = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (!INT) dips++;
      end
      check("int_set_wins", 16'(dips), 16'd0);
      #200;

      // reset in the middle of a frame
      fork
         spi_frame(16'h8F00, 16, 1'b0, 8'h00);
         begin
            #900;
            rst_n = 1'b0;
            #30;
            rst_n = 1'b1;
         end
      join
      @(negedge clk);
      check("int_after_rst", {15'd0, INT}, 16'd0);
      check("setup_done_after_rst", {15'd0, setup_done}, 16'd0);
      #200;
      rd(16'h8D00, 8'h00);
      rd(16'h9000, 8'h00);
      rd(16'hA300, 8'h00);
      rd(16'h8F00, 8'h6A);
      repeat (100) @(negedge clk);
      check("int_stays_low", {15'd0, INT}, 16'd0);

      check("sb_empty", 16'(sb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
